chimp_press_encoder: RTL and testbench
======================================

CHIMP_PRESS_ENCODER -- requirements
Module: chimp_press_encoder

Interface
REQ-001 SHALL have parameter COLS, default 8, grid columns; only value 8 is supported.
REQ-002 SHALL have parameter ROWS, default 4, grid rows; only value 4 is supported, giving 32 cells with index = row*8 + col.
REQ-003 clk  in  1  system clock; all state changes on the rising edge.
REQ-004 iKey0  in  1  reset, asynchronous and active-high.
REQ-005 iClear  in  1  synchronous clear of every cell.
REQ-006 iWrEn  in  1  loader write strobe.
REQ-007 iWrCell  in  5  cell index to write.
REQ-008 iWrNum  in  5  tile number to store; 0 empties the cell.
REQ-009 iUp, iDown, iLeft, iRight  in  1 each  level-sensitive cursor buttons, synchronous to clk, active-high.
REQ-010 iSelect  in  1  level-sensitive select button, synchronous to clk, active-high.
REQ-011 oPressNum  out  6  one-cycle press pulse carrying the selected tile number (1..31); 0 when idle.
REQ-012 oCursorCol  out  3  registered cursor column.
REQ-013 oCursorRow  out  2  registered cursor row.
REQ-014 oCellOcc  out  32  occupancy bitmap; bit i = (cell i number != 0).
REQ-015 oRemaining  out  6  count of occupied cells, 0..32, combinational from the cell array.

Function
REQ-016 SHALL hold 32 five-bit registered cells; the cell value is the tile number, and 0 = empty.
REQ-017 SHALL register the previous value of each of the 5 buttons; an event = current high AND previous low (rising edge); a held button SHALL produce exactly one event until it is released.
REQ-018 Up event: row <= row-1, wrapping 0 -> 3; Down event: row+1, wrapping 3 -> 0.
REQ-019 Left event: col-1, wrapping 0 -> 7; Right event: col+1, wrapping 7 -> 0.
REQ-020 Simultaneous Up+Down events: only Up applies; Left+Right: only Left applies; a vertical and a horizontal event in the same cycle SHALL both apply.
REQ-021 Select event at edge N with the cursor cell nonzero: oPressNum = cell value for exactly the cycle after edge N, and the cell becomes 0 at edge N.
REQ-022 Select event on an empty cell SHALL produce no pulse; oPressNum stays 0.
REQ-023 A select event in the same cycle as a cursor event SHALL use the pre-move cursor position.
REQ-024 oPressNum SHALL be registered, 0 in every cycle without a qualifying select event; bit 5 is always 0.
REQ-025 Cell write priority at an edge: iClear over iWrEn over select-clear; iClear zeroes all cells; iWrEn writes iWrNum into iWrCell.
REQ-026 When iWrEn or iClear targets the selected cell in the same cycle as a select event, the pulse SHALL still carry the pre-edge value, and the cell SHALL take the write or clear value.
REQ-027 iClear and iWrEn SHALL not affect the cursor or the edge registers.
REQ-028 oCellOcc and oRemaining SHALL reflect the cell array after the edge (zero latency from the registers).

Reset
REQ-029 When iKey0 is asserted, the block SHALL immediately, without waiting for a clock edge, set all cells to 0, cursor to (row 0, col 0), oPressNum to 0, oRemaining to 0 and oCellOcc to 0.
REQ-030 Reset SHALL set all five previous-button registers to 1, so a button held through reset release generates no event until it is released and pressed again.
REQ-031 Reset asserted mid-pulse SHALL force oPressNum to 0 at once; no pulse SHALL be emitted after reset release.

Verification
REQ-032 Write cell 0 = 1 and cell 9 = 2, then pulse iSelect at (0,0) -> oPressNum = 1 for exactly one cycle; oCellOcc bit 0 = 0; oRemaining = 1.
REQ-033 From (0,0): one Left event -> col 7; one Up event -> row 3; Left+Right together -> col 6; Down then Right -> (0,7).
REQ-034 Hold iSelect high for 10 cycles on a cell holding 5 -> exactly one pulse of value 5; a second press on the now-empty cell -> no pulse.
REQ-035 Same cycle: select event at cell 3 (value 4), iWrEn to cell 3 with value 7, Right event -> pulse = 4, cell 3 = 7, col advances by 1.
REQ-036 Hold iSelect through iKey0 assertion and release -> no pulse until iSelect falls and rises again.
REQ-037 Assert iKey0 in the cycle oPressNum = 3 -> output is 0 immediately, and all cells and the cursor are cleared.

Source files
------------

// File: rtl/chimp_press_encoder.sv
// Tile-grid press encoder: 8x4 cell store, edge-detected cursor buttons, and a
// one-cycle press pulse that reports and empties the tile under the cursor.

module chimp_press_cell #(
  parameter int CELL_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr_hit,
  input  logic [CELL_W-1:0] wr_num,
  input  logic              sel_hit,
  output logic [CELL_W-1:0] value,
  output logic              occ
);
  // Loader writes outrank the select-clear so a same-cycle reload survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          value <= '0;
    else if (clear)   value <= '0;
    else if (wr_hit)  value <= wr_num;
    else if (sel_hit) value <= '0;
  end

  assign occ = |value;
endmodule

module chimp_press_encoder #(
  parameter int COLS = 8,
  parameter int ROWS = 4
) (
  input  logic        clk,
  input  logic        iKey0,
  input  logic        iClear,
  input  logic        iWrEn,
  input  logic [4:0]  iWrCell,
  input  logic [4:0]  iWrNum,
  input  logic        iUp,
  input  logic        iDown,
  input  logic        iLeft,
  input  logic        iRight,
  input  logic        iSelect,
  output logic [5:0]  oPressNum,
  output logic [2:0]  oCursorCol,
  output logic [1:0]  oCursorRow,
  output logic [31:0] oCellOcc,
  output logic [5:0]  oRemaining
);
  localparam int NUM_CELLS = COLS * ROWS;
  localparam int CELL_W    = 5;

  logic [NUM_CELLS-1:0][CELL_W-1:0] cell_val;
  logic [NUM_CELLS-1:0]             cell_occ;
  logic [NUM_CELLS-1:0]             wr_hit;
  logic [NUM_CELLS-1:0]             sel_hit;

  logic [4:0]        btn, btn_prev, ev;
  logic              up_ev, down_ev, left_ev, right_ev, sel_ev;
  logic [1:0]        row;
  logic [2:0]        col;
  logic [4:0]        cur_idx;
  logic [CELL_W-1:0] cur_val;
  logic [5:0]        press;
  logic [5:0]        remaining;

  assign btn      = {iSelect, iRight, iLeft, iDown, iUp};
  assign ev       = btn & ~btn_prev;
  assign up_ev    = ev[0];
  assign down_ev  = ev[1];
  assign left_ev  = ev[2];
  assign right_ev = ev[3];
  assign sel_ev   = ev[4];

  // Row-major index: row*8 + col is just the concatenation.
  assign cur_idx = {row, col};
  assign cur_val = cell_val[cur_idx];

  genvar g;
  generate
    for (g = 0; g < NUM_CELLS; g++) begin : g_cell
      assign wr_hit[g]  = iWrEn  && (iWrCell == 5'(g));
      assign sel_hit[g] = sel_ev && (cur_idx == 5'(g));

      chimp_press_cell #(.CELL_W(CELL_W)) u_cell (
        .clk     (clk),
        .rst     (iKey0),
        .clear   (iClear),
        .wr_hit  (wr_hit[g]),
        .wr_num  (iWrNum),
        .sel_hit (sel_hit[g]),
        .value   (cell_val[g]),
        .occ     (cell_occ[g])
      );
    end
  endgenerate

  // Previous-button state resets high so a button held through reset stays quiet.
  always_ff @(posedge clk or posedge iKey0) begin
    if (iKey0) btn_prev <= '1;
    else       btn_prev <= btn;
  end

  // Up beats Down, Left beats Right; 2-/3-bit arithmetic gives the wrap for free.
  always_ff @(posedge clk or posedge iKey0) begin
    if (iKey0) begin
      row <= '0;
      col <= '0;
    end else begin
      if (up_ev)        row <= row - 2'd1;
      else if (down_ev) row <= row + 2'd1;
      if (left_ev)       col <= col - 3'd1;
      else if (right_ev) col <= col + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge iKey0) begin
    if (iKey0)                       press <= '0;
    else if (sel_ev && cur_val != 0) press <= {1'b0, cur_val};
    else                             press <= '0;
  end

  always_comb begin
    remaining = '0;
    for (int i = 0; i < NUM_CELLS; i++)
      remaining = remaining + 6'(cell_occ[i]);
  end

  assign oPressNum  = press;
  assign oCursorCol = col;
  assign oCursorRow = row;
  assign oCellOcc   = cell_occ;
  assign oRemaining = remaining;
endmodule

// File: tb/tb_chimp_press_encoder.sv
// Bench for chimp_press_encoder: directed vector table, corner sequences, and
// random traffic checked against a cell/cursor reference model.

module tb_chimp_press_encoder;
  logic        clk = 0;
  logic        iKey0 = 1;
  logic        iClear = 0, iWrEn = 0;
  logic [4:0]  iWrCell = 0, iWrNum = 0;
  logic        iUp = 0, iDown = 0, iLeft = 0, iRight = 0, iSelect = 0;
  logic [5:0]  oPressNum;
  logic [2:0]  oCursorCol;
  logic [1:0]  oCursorRow;
  logic [31:0] oCellOcc;
  logic [5:0]  oRemaining;

  int errors = 0;
  int checks = 0;

  chimp_press_encoder #(.COLS(8), .ROWS(4)) dut (
    .clk(clk), .iKey0(iKey0), .iClear(iClear), .iWrEn(iWrEn),
    .iWrCell(iWrCell), .iWrNum(iWrNum), .iUp(iUp), .iDown(iDown),
    .iLeft(iLeft), .iRight(iRight), .iSelect(iSelect),
    .oPressNum(oPressNum), .oCursorCol(oCursorCol), .oCursorRow(oCursorRow),
    .oCellOcc(oCellOcc), .oRemaining(oRemaining)
  );

  always #5 clk = ~clk;

  // Reference model: tile numbers per cell, cursor as plain integers.
  int m_cells[32];
  int m_row, m_col, m_press;
  bit m_prev_up, m_prev_dn, m_prev_lf, m_prev_rt, m_prev_sel;

  task automatic model_reset();
    foreach (m_cells[i]) m_cells[i] = 0;
    m_row = 0; m_col = 0; m_press = 0;
    m_prev_up = 1; m_prev_dn = 1; m_prev_lf = 1; m_prev_rt = 1; m_prev_sel = 1;
  endtask

  task automatic model_edge();
    bit e_up, e_dn, e_lf, e_rt, e_sel;
    int idx;
    e_up  = iUp     && !m_prev_up;
    e_dn  = iDown   && !m_prev_dn;
    e_lf  = iLeft   && !m_prev_lf;
    e_rt  = iRight  && !m_prev_rt;
    e_sel = iSelect && !m_prev_sel;
    idx = m_row * 8 + m_col;
    m_press = (e_sel && m_cells[idx] != 0) ? m_cells[idx] : 0;
    if (iClear) foreach (m_cells[i]) m_cells[i] = 0;
    else begin
      if (e_sel) m_cells[idx] = 0;
      if (iWrEn) m_cells[int'(iWrCell)] = int'(iWrNum);
    end
    if (e_up)      m_row = (m_row + 3) % 4;
    else if (e_dn) m_row = (m_row + 1) % 4;
    if (e_lf)      m_col = (m_col + 7) % 8;
    else if (e_rt) m_col = (m_col + 1) % 8;
    m_prev_up = iUp; m_prev_dn = iDown; m_prev_lf = iLeft;
    m_prev_rt = iRight; m_prev_sel = iSelect;
  endtask

  function automatic int m_remaining();
    int n = 0;
    foreach (m_cells[i]) if (m_cells[i] != 0) n++;
    return n;
  endfunction

  function automatic logic [31:0] m_occ();
    logic [31:0] o = '0;
    foreach (m_cells[i]) o[i] = (m_cells[i] != 0);
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " press"}, 32'(oPressNum), 32'(m_press));
    chk({tag, " row"},   32'(oCursorRow), 32'(m_row));
    chk({tag, " col"},   32'(oCursorCol), 32'(m_col));
    chk({tag, " rem"},   32'(oRemaining), 32'(m_remaining()));
    chk({tag, " occ"},   oCellOcc, m_occ());
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit up, dn, lf, rt, sel, wr, input int wc, wn, input bit clr);
    iUp = up; iDown = dn; iLeft = lf; iRight = rt; iSelect = sel;
    iWrEn = wr; iWrCell = 5'(wc); iWrNum = 5'(wn); iClear = clr;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, iSelect, 0, 0, 0, 0);
  endtask

  // Asserts reset mid-cycle and checks it takes effect without a clock edge.
  task automatic do_reset(input string tag);
    iKey0 = 1;
    #1;
    model_reset();
    chk({tag, " rst press"}, 32'(oPressNum), 0);
    chk({tag, " rst row"},   32'(oCursorRow), 0);
    chk({tag, " rst col"},   32'(oCursorCol), 0);
    chk({tag, " rst rem"},   32'(oRemaining), 0);
    chk({tag, " rst occ"},   oCellOcc, 0);
    @(negedge clk);
    iKey0 = 0;
  endtask

  typedef struct {
    bit up, dn, lf, rt, sel, wr;
    int wc, wn;
    bit clr;
    int row, col, press, rem;
    logic [31:0] occ;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit up, dn, lf, rt, sel, wr, input int wc, wn,
                     input int row, col, press, rem, input logic [31:0] occ);
    vec_t v;
    v.up = up; v.dn = dn; v.lf = lf; v.rt = rt; v.sel = sel; v.wr = wr;
    v.wc = wc; v.wn = wn; v.clr = 0;
    v.row = row; v.col = col; v.press = press; v.rem = rem; v.occ = occ;
    tbl.push_back(v);
  endtask

  initial begin
    int pulses, pval;

    //  up dn lf rt sel wr  wc wn   row col press rem occ
    add(0, 0, 0, 0, 0, 1,  0, 1,    0,  0,  0,   1, 32'h1);
    add(0, 0, 0, 0, 0, 1,  9, 2,    0,  0,  0,   2, 32'h201);
    add(0, 0, 0, 0, 1, 0,  0, 0,    0,  0,  1,   1, 32'h200);
    add(0, 0, 0, 0, 0, 0,  0, 0,    0,  0,  0,   1, 32'h200);
    add(0, 0, 1, 0, 0, 0,  0, 0,    0,  7,  0,   1, 32'h200);
    add(0, 0, 0, 0, 0, 0,  0, 0,    0,  7,  0,   1, 32'h200);
    add(1, 0, 0, 0, 0, 0,  0, 0,    3,  7,  0,   1, 32'h200);
    add(0, 0, 0, 0, 0, 0,  0, 0,    3,  7,  0,   1, 32'h200);
    add(0, 0, 1, 1, 0, 0,  0, 0,    3,  6,  0,   1, 32'h200);
    add(0, 0, 0, 0, 0, 0,  0, 0,    3,  6,  0,   1, 32'h200);
    add(0, 1, 0, 0, 0, 0,  0, 0,    0,  6,  0,   1, 32'h200);
    add(0, 0, 0, 0, 0, 0,  0, 0,    0,  6,  0,   1, 32'h200);
    add(0, 0, 0, 1, 0, 0,  0, 0,    0,  7,  0,   1, 32'h200);
    add(0, 0, 0, 0, 0, 0,  0, 0,    0,  7,  0,   1, 32'h200);
    add(0, 0, 0, 1, 0, 0,  0, 0,    0,  0,  0,   1, 32'h200);
    add(0, 0, 0, 0, 0, 0,  0, 0,    0,  0,  0,   1, 32'h200);
    add(0, 0, 0, 1, 0, 0,  0, 0,    0,  1,  0,   1, 32'h200);
    add(0, 0, 0, 0, 0, 0,  0, 0,    0,  1,  0,   1, 32'h200);
    add(0, 0, 0, 1, 0, 0,  0, 0,    0,  2,  0,   1, 32'h200);
    add(0, 0, 0, 0, 0, 0,  0, 0,    0,  2,  0,   1, 32'h200);
    add(0, 0, 0, 1, 0, 0,  0, 0,    0,  3,  0,   1, 32'h200);
    add(0, 0, 0, 0, 0, 1,  3, 4,    0,  3,  0,   2, 32'h208);
    add(0, 0, 0, 1, 1, 1,  3, 7,    0,  4,  4,   2, 32'h208);
    add(0, 0, 0, 0, 0, 0,  0, 0,    0,  4,  0,   2, 32'h208);
    add(0, 0, 1, 0, 0, 0,  0, 0,    0,  3,  0,   2, 32'h208);
    add(0, 0, 0, 0, 0, 0,  0, 0,    0,  3,  0,   2, 32'h208);
    add(0, 0, 0, 0, 1, 0,  0, 0,    0,  3,  7,   1, 32'h200);
    add(0, 0, 0, 0, 0, 0,  0, 0,    0,  3,  0,   1, 32'h200);

    model_reset();
    #1;
    chk("init press", 32'(oPressNum), 0);
    chk("init rem",   32'(oRemaining), 0);
    chk("init occ",   oCellOcc, 0);
    @(negedge clk);
    iKey0 = 0;

    foreach (tbl[i]) begin
      drive(tbl[i].up, tbl[i].dn, tbl[i].lf, tbl[i].rt, tbl[i].sel, tbl[i].wr,
            tbl[i].wc, tbl[i].wn, tbl[i].clr);
      step();
      chk($sformatf("vec%0d row", i),   32'(oCursorRow), 32'(tbl[i].row));
      chk($sformatf("vec%0d col", i),   32'(oCursorCol), 32'(tbl[i].col));
      chk($sformatf("vec%0d press", i), 32'(oPressNum),  32'(tbl[i].press));
      chk($sformatf("vec%0d rem", i),   32'(oRemaining), 32'(tbl[i].rem));
      chk($sformatf("vec%0d occ", i),   oCellOcc, tbl[i].occ);
    end

    // Held select on a cell holding 5: one pulse only, then nothing on re-press.
    drive(0, 0, 0, 0, 0, 1, 3, 5, 0);
    step();
    idle();
    iSelect = 1;
    pulses = 0; pval = 0;
    repeat (10) begin
      step();
      if (oPressNum != 0) begin pulses++; pval = int'(oPressNum); end
    end
    chk("hold pulses", 32'(pulses), 1);
    chk("hold value", 32'(pval), 5);
    iSelect = 0; step();
    iSelect = 1; pulses = 0;
    repeat (2) begin step(); if (oPressNum != 0) pulses++; end
    chk("empty re-press pulses", 32'(pulses), 0);

    // Select held across reset stays quiet until released and pressed again.
    do_reset("held");
    drive(0, 0, 0, 0, 1, 1, 0, 6, 0);
    step();
    idle();
    pulses = 0;
    repeat (5) begin step(); if (oPressNum != 0) pulses++; end
    chk("held-through-reset pulses", 32'(pulses), 0);
    iSelect = 0; step();
    iSelect = 1; step();
    chk("repress after reset", 32'(oPressNum), 6);
    iSelect = 0; step();
    chk("repress pulse width", 32'(oPressNum), 0);

    // Reset landing on the cycle a pulse is out.
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 1, 1, 3, 0); step();
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0); step();
    chk("pre-reset pulse", 32'(oPressNum), 3);
    do_reset("mid-pulse");
    idle(); iSelect = 0;
    step();
    chk("post-reset press", 32'(oPressNum), 0);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      iUp     = ($urandom_range(0, 9) < 3);
      iDown   = ($urandom_range(0, 9) < 3);
      iLeft   = ($urandom_range(0, 9) < 3);
      iRight  = ($urandom_range(0, 9) < 3);
      iSelect = ($urandom_range(0, 9) < 4);
      iWrEn   = ($urandom_range(0, 9) < 4);
      iWrCell = 5'($urandom_range(0, 31));
      iWrNum  = 5'($urandom_range(0, 31));
      iClear  = ($urandom_range(0, 99) < 2);
      step();
      check_model($sformatf("rnd%0d", c));
      if ($urandom_range(0, 199) == 0) do_reset($sformatf("rnd%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end
endmodule
